regfile_op_sequencer: RTL and testbench
=======================================

// Module: regfile_op_sequencer
// PURPOSE
//   Initiator side of the 32-bit register file port set (ra1/ra2/wa/wd/we).
//   Accepts one register-to-register op per valid/ready handshake, reads both
//   operands, executes in a small ALU, and writes the result back. Sits between
//   the instruction source and the register file in the 32-bit processor datapath.
// PARAMETERS
//   RWIDTH  6   register address width (2**RWIDTH registers)
//   DWIDTH  32  data width
// PORTS
//   clk        in   1       clock, all logic on posedge
//   rst_n      in   1       synchronous active-low reset
//   in_valid   in   1       op request valid
//   in_ready   out  1       sequencer can accept an op
//   in_op      in   3       opcode (see BEHAVIOUR)
//   in_src1    in   RWIDTH  operand A register
//   in_src2    in   RWIDTH  operand B register
//   in_dst     in   RWIDTH  destination register
//   in_imm     in   DWIDTH  immediate, used by LDI only
//   rf_ra1     out  RWIDTH  to register file ra1
//   rf_ra2     out  RWIDTH  to register file ra2
//   rf_wa      out  RWIDTH  to register file wa
//   rf_wd      out  DWIDTH  to register file wd
//   rf_we      out  1       to register file we
//   rf_rd1     in   DWIDTH  from register file rd1 (1-cycle registered read)
//   rf_rd2     in   DWIDTH  from register file rd2
//   done       out  1       one-cycle pulse, result written this cycle
//   result     out  DWIDTH  value written (valid while done)
//   flag_zero  out  1       result == 0 (valid while done)
//   flag_carry out  1       carry-out of ADD/SUB, else 0
//   flag_ovf   out  1       signed overflow of ADD/SUB, else 0
// BEHAVIOUR
//   Opcodes: 000 ADD, 001 SUB (A + ~B + 1), 010 AND, 011 OR, 100 XOR,
//     101 SLT (signed, result 0/1), 110 SLL (A << B[4:0]), 111 LDI (result=in_imm).
//   Carry = bit DWIDTH of 33-bit sum; SUB carry=1 means no borrow.
//   FSM: IDLE -> READ -> EXEC -> WRITE -> (IDLE | READ).
//   - in_ready=1 in IDLE and WRITE only; handshake = in_valid & in_ready;
//     op fields latched on handshake edge.
//   - READ: rf_ra1/rf_ra2 = latched src1/src2, rf_we=0.
//   - EXEC: rf_rd1/rf_rd2 valid; ALU result and flags registered at cycle end.
//   - WRITE: rf_we=1, rf_wa=dst, rf_wd=result, done=1. Handshake in WRITE -> READ
//     (back-to-back, one op per 3 cycles); else -> IDLE.
//   Latency: accept at edge T, done high in cycle T+3.
//   RAW on back-to-back ops needs no bypass: write lands at edge ending WRITE,
//   next READ samples after it.
//   rf_we is 0 in every state except WRITE (register file reads only when we=0).
//   rf_* outputs decoded from state + latched regs; no extra pipeline stage.
//   Reset (any state, incl. mid-op): next state IDLE (or CLEAR), in_ready=0
//   during the reset cycle, done=0, rf_we=0, result/flags=0, latched op=0;
//   aborted op never writes.
// CONFIGURATION
//   REGSEQ_CLEAR_EN defined: after reset FSM enters CLEAR, writes 0 to addresses
//     0..2**RWIDTH-1, one per cycle (rf_we=1, done=0), in_ready=0; then IDLE.
//   Undefined: reset goes directly to IDLE; register contents undefined.
// STRUCTURE
//   regseq_pkg: opcode enum op_e, state enum state_e (IDLE/READ/EXEC/WRITE/CLEAR),
//     default RWIDTH/DWIDTH localparams.
//   One sub-module: regseq_alu (combinational A, B, op, imm -> result, flags).
// TESTING
//   Reset 2 cycles -> in_ready=0, rf_we=0, done=0; with REGSEQ_CLEAR_EN 64 zero
//     writes (wa 0..63) then in_ready=1.
//   LDI r1=5, LDI r2=7, ADD r3=r1+r2 -> done at T+3, rf_wa=3, result=12, zero=0.
//   SUB r4=r1-r1 -> result=0, flag_zero=1, flag_carry=1, flag_ovf=0.
//   LDI r1=0x7FFFFFFF, LDI r2=1, ADD -> 0x80000000, flag_ovf=1, flag_carry=0.
//   Back-to-back ADD r5=r1+r2 then ADD r6=r5+r5 (r1=5,r2=7) -> r6=24, 3-cycle spacing.
//   rst_n low during EXEC of ADD r7 -> no rf_we for r7; later read of r7 unchanged.

Source files
------------

// File: rtl/regseq_pkg.sv
// rtl/regseq_pkg.sv - shared types and default widths for the register-file op sequencer
package regseq_pkg;

    localparam int RWIDTH_DEF = 6;
    localparam int DWIDTH_DEF = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_LDI = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CLEAR = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_op_sequencer_if.sv
// rtl/regfile_op_sequencer_if.sv - op request bus and register-file port bus of the sequencer
interface regseq_op_if
    import regseq_pkg::*;
#(
    parameter int RWIDTH = RWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [RWIDTH-1:0] in_src1;
    logic [RWIDTH-1:0] in_src2;
    logic [RWIDTH-1:0] in_dst;
    logic [DWIDTH-1:0] in_imm;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_dst, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_dst, in_imm,
        output in_ready
    );
endinterface

interface regseq_rf_if
    import regseq_pkg::*;
#(
    parameter int RWIDTH = RWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
);
    logic [RWIDTH-1:0] rf_ra1;
    logic [RWIDTH-1:0] rf_ra2;
    logic [RWIDTH-1:0] rf_wa;
    logic [DWIDTH-1:0] rf_wd;
    logic              rf_we;
    logic [DWIDTH-1:0] rf_rd1;
    logic [DWIDTH-1:0] rf_rd2;

    modport master (
        output rf_ra1, rf_ra2, rf_wa, rf_wd, rf_we,
        input  rf_rd1, rf_rd2
    );

    modport slave (
        input  rf_ra1, rf_ra2, rf_wa, rf_wd, rf_we,
        output rf_rd1, rf_rd2
    );
endinterface

// File: rtl/regseq_alu.sv
// rtl/regseq_alu.sv - combinational ALU: operands, opcode and immediate to result and flags
module regseq_alu
    import regseq_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic [DWIDTH-1:0] i_a,
    input  logic [DWIDTH-1:0] i_b,
    input  logic [DWIDTH-1:0] i_imm,
    input  op_e               i_op,
    output logic [DWIDTH-1:0] o_result,
    output logic              o_zero,
    output logic              o_carry,
    output logic              o_ovf
);

    logic [DWIDTH-1:0] w_b_eff;
    logic [DWIDTH:0]   w_sum;
    logic              w_is_sub;

    // SUB shares the adder as A + ~B + 1 so carry=1 reads as "no borrow"
    always_comb begin
        w_is_sub = (i_op == OP_SUB);
        w_b_eff  = w_is_sub ? ~i_b : i_b;
        w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + {{DWIDTH{1'b0}}, w_is_sub};
    end

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        o_ovf    = 1'b0;
        case (i_op)
            OP_ADD, OP_SUB: begin
                o_result = w_sum[DWIDTH-1:0];
                o_carry  = w_sum[DWIDTH];
                o_ovf    = (i_a[DWIDTH-1] == w_b_eff[DWIDTH-1]) &&
                           (w_sum[DWIDTH-1] != i_a[DWIDTH-1]);
            end
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_SLT: o_result = {{(DWIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_SLL: o_result = i_a << i_b[4:0];
            OP_LDI: o_result = i_imm;
            default: o_result = '0;
        endcase
        o_zero = (o_result == '0);
    end

endmodule

// File: rtl/regfile_op_sequencer.sv
// rtl/regfile_op_sequencer.sv - read/exec/write sequencer driving the register file; REGSEQ_CLEAR_EN adds a post-reset zero-fill
module regfile_op_sequencer
    import regseq_pkg::*;
#(
    parameter int RWIDTH = RWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    regseq_op_if.slave        op_bus,
    regseq_rf_if.master       rf_bus,
    output logic              done,
    output logic [DWIDTH-1:0] result,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              flag_ovf
);

    state_e            r_state;
    state_e            w_next;
    op_e               r_op;
    logic [RWIDTH-1:0] r_src1;
    logic [RWIDTH-1:0] r_src2;
    logic [RWIDTH-1:0] r_dst;
    logic [RWIDTH-1:0] r_clr_addr;
    logic [DWIDTH-1:0] r_imm;
    logic [DWIDTH-1:0] r_result;
    logic              r_zero;
    logic              r_carry;
    logic              r_ovf;

    logic              w_ready;
    logic              w_accept;
    logic              w_we;
    logic              w_done;
    logic [RWIDTH-1:0] w_wa;
    logic [DWIDTH-1:0] w_wd;
    logic [DWIDTH-1:0] w_alu_result;
    logic              w_alu_zero;
    logic              w_alu_carry;
    logic              w_alu_ovf;

    regseq_alu #(.DWIDTH(DWIDTH)) u_alu (
        .i_a      (rf_bus.rf_rd1),
        .i_b      (rf_bus.rf_rd2),
        .i_imm    (r_imm),
        .i_op     (r_op),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero),
        .o_carry  (w_alu_carry),
        .o_ovf    (w_alu_ovf)
    );

    // Strobes are masked by rst_n so an op caught mid-flight by reset never writes
    always_comb begin
        w_ready = 1'b0;
        w_we    = 1'b0;
        w_done  = 1'b0;
        w_wa    = r_dst;
        w_wd    = '0;
        case (r_state)
            ST_IDLE:  w_ready = 1'b1;
            ST_WRITE: begin
                w_ready = 1'b1;
                w_we    = 1'b1;
                w_done  = 1'b1;
                w_wd    = r_result;
            end
            ST_CLEAR: begin
                w_we = 1'b1;
                w_wa = r_clr_addr;
            end
            default: w_ready = 1'b0;
        endcase
        if (!rst_n) begin
            w_ready = 1'b0;
            w_we    = 1'b0;
            w_done  = 1'b0;
        end
    end

    assign w_accept = op_bus.in_valid & w_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_READ;
            ST_READ:  w_next = ST_EXEC;
            ST_EXEC:  w_next = ST_WRITE;
            ST_WRITE: w_next = w_accept ? ST_READ : ST_IDLE;
            ST_CLEAR: if (r_clr_addr == {RWIDTH{1'b1}}) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
`ifdef REGSEQ_CLEAR_EN
            r_state <= ST_CLEAR;
`else
            r_state <= ST_IDLE;
`endif
            r_op       <= OP_ADD;
            r_src1     <= '0;
            r_src2     <= '0;
            r_dst      <= '0;
            r_imm      <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op   <= op_e'(op_bus.in_op);
                r_src1 <= op_bus.in_src1;
                r_src2 <= op_bus.in_src2;
                r_dst  <= op_bus.in_dst;
                r_imm  <= op_bus.in_imm;
            end
            // Register-file read data is valid only during EXEC
            if (r_state == ST_EXEC) begin
                r_result <= w_alu_result;
                r_zero   <= w_alu_zero;
                r_carry  <= w_alu_carry;
                r_ovf    <= w_alu_ovf;
            end
            if (r_state == ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
        end
    end

    assign op_bus.in_ready = w_ready;
    assign rf_bus.rf_ra1   = r_src1;
    assign rf_bus.rf_ra2   = r_src2;
    assign rf_bus.rf_wa    = w_wa;
    assign rf_bus.rf_wd    = w_wd;
    assign rf_bus.rf_we    = w_we;
    assign done            = w_done;
    assign result          = r_result;
    assign flag_zero       = r_zero;
    assign flag_carry      = r_carry;
    assign flag_ovf        = r_ovf;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// tb/tb_regfile_op_sequencer.sv - directed bench with register-file model and architectural scoreboard
module tb_regfile_op_sequencer;
    import regseq_pkg::*;

    localparam int RW   = 6;
    localparam int DW   = 32;
    localparam int NREG = 64;
`ifdef REGSEQ_CLEAR_EN
    localparam logic [31:0] R7_EXP = 32'h0000_0000;
`else
    localparam logic [31:0] R7_EXP = 32'hA5A5_0007;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regseq_op_if #(.RWIDTH(RW), .DWIDTH(DW)) op_bus ();
    regseq_rf_if #(.RWIDTH(RW), .DWIDTH(DW)) rf_bus ();

    logic          done;
    logic [DW-1:0] result;
    logic          flag_zero;
    logic          flag_carry;
    logic          flag_ovf;

    regfile_op_sequencer #(.RWIDTH(RW), .DWIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_bus     (op_bus),
        .rf_bus     (rf_bus),
        .done       (done),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_ovf   (flag_ovf)
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    // Register file: 1-cycle registered read, write on we
    logic [DW-1:0] rf_mem [NREG];
    logic          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < NREG; i++) rf_mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else begin
            rf_bus.rf_rd1 <= rf_mem[rf_bus.rf_ra1];
            rf_bus.rf_rd2 <= rf_mem[rf_bus.rf_ra2];
            if (rf_bus.rf_we) rf_mem[rf_bus.rf_wa] <= rf_bus.rf_wd;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural reference: what the op means, computed with wide integer arithmetic
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] imm, output logic [31:0] r,
                                  output logic z, output logic c, output logic v);
        longint sa;
        longint sb;
        longint s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 32'h0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin
                r = a + b;
                c = ((longint'(a) + longint'(b)) > 64'sh0_FFFF_FFFF);
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: r = a << b[4:0];
            default: r = imm;
        endcase
        z = (r == 32'h0);
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [5:0]  s1;
        logic [5:0]  s2;
        logic [5:0]  d;
        logic [31:0] imm;
        int          acc;
    } tx_t;

    tx_t         q[$];
    logic [31:0] m_regs [NREG];
    logic [31:0] last_result;
    logic [5:0]  last_wa;
    logic        last_z, last_c, last_v;
    int          last_done_cyc = 0;
    int          prev_done_cyc = 0;
    int          clear_idx = 0;

    // Compare process: checks every cycle against the architectural model
    initial begin
        tx_t         t;
        logic [31:0] er;
        logic        ez, ec, ev;
        for (int i = 0; i < NREG; i++) m_regs[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                clear_idx = 0;
                chk("rst_in_ready", 32'(op_bus.in_ready), 32'd0);
                chk("rst_rf_we", 32'(rf_bus.rf_we), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
            end
`ifdef REGSEQ_CLEAR_EN
            else if (clear_idx < NREG) begin
                chk("clr_we", 32'(rf_bus.rf_we), 32'd1);
                chk("clr_wa", 32'(rf_bus.rf_wa), clear_idx);
                chk("clr_wd", rf_bus.rf_wd, 32'd0);
                chk("clr_ready", 32'(op_bus.in_ready), 32'd0);
                chk("clr_done", 32'(done), 32'd0);
                m_regs[clear_idx] = 32'h0;
                clear_idx++;
            end
`endif
            else begin
                chk("we_only_with_done", 32'(rf_bus.rf_we), 32'(done));
                if (done) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL spurious_done: got done=1 expected no pending op (t=%0t)", $time);
                    end else begin
                        t = q.pop_front();
                        model(t.op, m_regs[t.s1], m_regs[t.s2], t.imm, er, ez, ec, ev);
                        chk("latency", cyc, t.acc + 2);
                        chk("rf_wa", 32'(rf_bus.rf_wa), 32'(t.d));
                        chk("rf_wd", rf_bus.rf_wd, er);
                        chk("result", result, er);
                        chk("flag_zero", 32'(flag_zero), 32'(ez));
                        chk("flag_carry", 32'(flag_carry), 32'(ec));
                        chk("flag_ovf", 32'(flag_ovf), 32'(ev));
                        m_regs[t.d]   = er;
                        last_result   = result;
                        last_wa       = rf_bus.rf_wa;
                        last_z        = flag_zero;
                        last_c        = flag_carry;
                        last_v        = flag_ovf;
                        prev_done_cyc = last_done_cyc;
                        last_done_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic send_op(input logic [2:0] op, input logic [5:0] s1, input logic [5:0] s2,
                           input logic [5:0] d, input logic [31:0] imm);
        tx_t t;
        bit  got;
        got = 1'b0;
        op_bus.in_valid = 1'b1;
        op_bus.in_op    = op;
        op_bus.in_src1  = s1;
        op_bus.in_src2  = s2;
        op_bus.in_dst   = d;
        op_bus.in_imm   = imm;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (op_bus.in_ready) begin
                @(posedge clk);
                #1;
                t.op = op; t.s1 = s1; t.s2 = s2; t.d = d; t.imm = imm; t.acc = cyc;
                q.push_back(t);
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 for 300 cycles expected a handshake");
        end
    endtask

    task automatic idle_n(input int n);
        op_bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (op_bus.in_ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("ready_after_reset", 32'(op_bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        op_bus.in_valid = 1'b0;
        op_bus.in_op    = 3'd0;
        op_bus.in_src1  = '0;
        op_bus.in_src2  = '0;
        op_bus.in_dst   = '0;
        op_bus.in_imm   = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_result", result, 32'd0);
        chk("post_rst_flags", {29'd0, flag_zero, flag_carry, flag_ovf}, 32'd0);
`ifdef REGSEQ_CLEAR_EN
        chk("clear_ready_low", 32'(op_bus.in_ready), 32'd0);
`endif
        wait_ready();
`ifdef REGSEQ_CLEAR_EN
        chk("clear_count", clear_idx, 32'd64);
`endif

        send_op(3'b111, 6'd0, 6'd0, 6'd1, 32'd5);
        send_op(3'b111, 6'd0, 6'd0, 6'd2, 32'd7);
        send_op(3'b000, 6'd1, 6'd2, 6'd3, 32'd0);
        idle_n(5);
        chk("add_result", last_result, 32'd12);
        chk("add_wa", 32'(last_wa), 32'd3);
        chk("add_zero", 32'(last_z), 32'd0);

        send_op(3'b001, 6'd1, 6'd1, 6'd4, 32'd0);
        idle_n(5);
        chk("sub_self_result", last_result, 32'd0);
        chk("sub_self_flags", {29'd0, last_z, last_c, last_v}, 32'b110);

        send_op(3'b111, 6'd0, 6'd0, 6'd1, 32'h7FFF_FFFF);
        send_op(3'b111, 6'd0, 6'd0, 6'd2, 32'd1);
        send_op(3'b000, 6'd1, 6'd2, 6'd3, 32'd0);
        idle_n(5);
        chk("add_ovf_result", last_result, 32'h8000_0000);
        chk("add_ovf_flags", {29'd0, last_z, last_c, last_v}, 32'b001);

        send_op(3'b111, 6'd0, 6'd0, 6'd1, 32'd5);
        send_op(3'b111, 6'd0, 6'd0, 6'd2, 32'd7);
        send_op(3'b000, 6'd1, 6'd2, 6'd5, 32'd0);
        send_op(3'b000, 6'd5, 6'd5, 6'd6, 32'd0);
        idle_n(5);
        chk("b2b_result", last_result, 32'd24);
        chk("b2b_spacing", last_done_cyc - prev_done_cyc, 32'd3);

        send_op(3'b010, 6'd5, 6'd6, 6'd10, 32'd0);
        send_op(3'b011, 6'd5, 6'd6, 6'd11, 32'd0);
        send_op(3'b100, 6'd5, 6'd6, 6'd12, 32'd0);
        send_op(3'b111, 6'd0, 6'd0, 6'd13, 32'hFFFF_FFFF);
        send_op(3'b101, 6'd13, 6'd1, 6'd14, 32'd0);
        idle_n(5);
        chk("slt_neg", last_result, 32'd1);
        send_op(3'b110, 6'd1, 6'd2, 6'd15, 32'd0);
        idle_n(5);
        chk("sll", last_result, 32'd640);
        send_op(3'b001, 6'd1, 6'd2, 6'd16, 32'd0);
        idle_n(5);
        chk("sub_borrow", last_result, 32'hFFFF_FFFE);
        chk("sub_borrow_carry", 32'(last_c), 32'd0);
        send_op(3'b111, 6'd0, 6'd0, 6'd17, 32'h8000_0000);
        send_op(3'b001, 6'd17, 6'd1, 6'd18, 32'd0);
        idle_n(5);
        chk("sub_ovf_result", last_result, 32'h7FFF_FFFB);
        chk("sub_ovf_flags", {29'd0, last_z, last_c, last_v}, 32'b011);

        send_op(3'b000, 6'd1, 6'd2, 6'd7, 32'd0);
        op_bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_r7_untouched", rf_mem[7], R7_EXP);
        chk("abort_result_cleared", result, 32'd0);
        wait_ready();

        send_op(3'b111, 6'd0, 6'd0, 6'd0, 32'd0);
        send_op(3'b000, 6'd7, 6'd0, 6'd9, 32'd0);
        idle_n(5);
        chk("r7_readback", last_result, R7_EXP);
        chk("pending_ops", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
